fifo_pack: RTL and testbench

Parametrised synchronous FIFO for the pixel/data streaming path, replacing the fixed 16×32 buffer. Provides a first-word-fall-through read port, an exact fill level, an almost-full threshold and a pack-available flag telling the downstream burst master that a full packet of `PACK_SIZE` words can be read without stalling. Sits between a stream producer (video input, DMA read side) and a burst consumer.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_pack_ram.sv | 23 ++
 rtl/fifo_pack.sv | 105 ++++++++++
 tb/tb_fifo_pack.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults, pointer type and parameter sanity check for the fifo_pack
// streaming buffer.
package fifo_pkg;

  localparam int FIFO_DATA_W    = 32;
  localparam int FIFO_ADDR_W    = 4;
  localparam int FIFO_PACK_SIZE = 8;

  // The extra MSB is the wrap bit that tells full apart from empty.
  typedef logic [FIFO_ADDR_W:0] fifo_ptr_t;

  function automatic bit fifo_params_ok(input int addr_w, input int pack_size,
                                        input int afull_lvl);
    int depth;
    depth = 1 << addr_w;
    return (pack_size >= 1) && (pack_size <= depth) &&
           (afull_lvl >= 1) && (afull_lvl <= depth);
  endfunction

endpackage

// File: rtl/fifo_pack_ram.sv
// Simple dual-port storage for fifo_pack: synchronous write on port A,
// asynchronous read on port B. Contents are deliberately never reset.
module fifo_pack_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_data;
  end

  assign b_data = mem[b_addr];

endmodule

// File: rtl/fifo_pack.sv
// Parametrised first-word-fall-through FIFO with registered level/status flags.
// Define FIFO_ERR_EN to build the sticky overflow/underflow flags.
import fifo_pkg::*;

module fifo_pack #(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int PACK_SIZE = FIFO_PACK_SIZE,
  parameter int AFULL_LVL = (2**ADDR_W) - 2
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [DATA_W-1:0] data_in,
  input  logic              w_e,
  input  logic              r_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              pack_available,
  output logic [ADDR_W:0]   level,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_V = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] PACK_V  = (ADDR_W+1)'(PACK_SIZE);

  if (!fifo_params_ok(ADDR_W, PACK_SIZE, AFULL_LVL)) begin : g_bad_params
    $error("fifo_pack: PACK_SIZE and AFULL_LVL must lie in 1..DEPTH");
  end

  logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, level_next;
  logic              we_eff, re_eff, bypass;
  logic [DATA_W-1:0] ram_rdata;

  // Gating uses the registered flags so no input reaches an output combinationally.
  always_comb begin
    we_eff      = w_e & ~full;
    re_eff      = r_ack & ~empty;
    wr_ptr_next = wr_ptr + {{ADDR_W{1'b0}}, we_eff};
    rd_ptr_next = rd_ptr + {{ADDR_W{1'b0}}, re_eff};
    level_next  = wr_ptr_next - rd_ptr_next;
    bypass      = we_eff && (wr_ptr[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
  end

  fifo_pack_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .a_we   (we_eff),
    .a_addr (wr_ptr[ADDR_W-1:0]),
    .a_data (data_in),
    .b_addr (rd_ptr_next[ADDR_W-1:0]),
    .b_data (ram_rdata)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      empty          <= 1'b1;
      full           <= 1'b0;
      almost_full    <= 1'b0;
      pack_available <= 1'b0;
      data_out       <= '0;
    end else begin
      wr_ptr         <= wr_ptr_next;
      rd_ptr         <= rd_ptr_next;
      level          <= level_next;
      empty          <= (level_next == '0);
      full           <= (level_next == DEPTH_V);
      almost_full    <= (level_next >= AFULL_V);
      pack_available <= (level_next >= PACK_V);
      // A word written into the slot about to become head is not in the RAM yet.
      data_out       <= bypass ? data_in : ram_rdata;
    end
  end

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_e && full)    overflow  <= 1'b1;
      if (r_ack && empty) underflow <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_pack.sv
// Scoreboard bench for fifo_pack: a queue model predicts data order, level,
// flags and (with FIFO_ERR_EN) the sticky error bits.
module tb_fifo_pack;

  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;
  localparam int PACK  = 8;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] data_in = '0;
  logic        w_e = 1'b0;
  logic        r_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] data_out;
  logic        full, empty, almost_full, pack_available, overflow, underflow;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int cur_level = 0, nxt_level = 0;
  bit cur_ovf = 0, nxt_ovf = 0, cur_udf = 0, nxt_udf = 0;

  fifo_pack dut (
    .clk            (clk),
    .nRST           (nRST),
    .data_in        (data_in),
    .w_e            (w_e),
    .r_ack          (r_ack),
    .data_out       (data_out),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .pack_available (pack_available),
    .level          (level),
    .err_clr        (err_clr),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs after the edge and advances the model to the
  // state the next edge will produce.
  task automatic applyStimulus(input bit we, input bit re, input bit clr, input logic [31:0] d);
    bit wacc, racc;
    @(posedge clk); #1;
    cur_level = nxt_level; cur_ovf = nxt_ovf; cur_udf = nxt_udf;
    w_e = we; r_ack = re; err_clr = clr; data_in = d;
    wacc = we && (cur_level < DEPTH);
    racc = re && (cur_level > 0);
    if (wacc) exp_q.push_back(d);
    nxt_level = cur_level + int'(wacc) - int'(racc);
`ifdef FIFO_ERR_EN
    nxt_ovf = clr ? 1'b0 : (cur_ovf | (we && cur_level == DEPTH));
    nxt_udf = clr ? 1'b0 : (cur_udf | (re && cur_level == 0));
`endif
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    w_e = 0; r_ack = 0; err_clr = 0;
    nRST = 1'b0;
    #1;
    checkOutput("async_reset", {empty, full, almost_full, pack_available, overflow, underflow, level, data_out},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
    cur_level = 0; nxt_level = 0;
    cur_ovf = 0; nxt_ovf = 0; cur_udf = 0; nxt_udf = 0;
    exp_q.delete();
    @(negedge clk); #1;
    nRST = 1'b1;
  endtask

  // Monitor: status every cycle, head word whenever the model holds data.
  always @(negedge clk) begin
    checkOutput("status", {full, empty, almost_full, pack_available, level},
                {cur_level == DEPTH, cur_level == 0, cur_level >= AFULL, cur_level >= PACK, 5'(cur_level)});
    checkOutput("err_flags", {overflow, underflow}, {cur_ovf, cur_udf});
    if (cur_level > 0) begin
      if (exp_q.size() == 0) begin
        checkOutput("scoreboard_underrun", 64'd1, 64'd0);
      end else begin
        checkOutput("data_out", data_out, exp_q[0]);
        if (r_ack) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    repeat (3) applyStimulus(0, 0, 0, 0);

    applyStimulus(1, 0, 0, 32'hA5A5_A5A5);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);

    // Fill, overfill, clear, drain.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 32'(i));
    applyStimulus(1, 0, 0, 32'hFFFF_0000);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Packet threshold.
    for (int i = 0; i < PACK - 1; i++) applyStimulus(1, 0, 0, 32'h100 + 32'(i));
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 32'h1FF);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < PACK - 1; i++) applyStimulus(0, 1, 0, 0);

    // Simultaneous read/write starting from full, across pointer wrap.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 32'h200 + 32'(i));
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'h300 + 32'(i));
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(0, 1, 0, 0);

    // Simultaneous read/write on empty, then underflow and clear.
    applyStimulus(1, 1, 0, 32'h0000_1234);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);

    // Reset mid-stream with nine words stored.
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 32'h400 + 32'(i));
    doReset();
    applyStimulus(1, 0, 0, 32'h0000_DEAD);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);

    // Random traffic alternating between fill-heavy and drain-heavy phases.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 1) ? 80 : 30;
      applyStimulus($urandom_range(99) < wp, $urandom_range(99) < (100 - wp),
                    $urandom_range(31) == 0, $urandom);
    end
    applyStimulus(0, 0, 0, 0);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
